mem_arbiter: RTL

- Shares one single-port unified memory between the core's instruction-fetch port and its load/store data port.
- Picks one requester at a time (round-robin on ties), runs a req/ready transaction to memory, and returns read data with a one-cycle valid pulse.
- Enforces a memory-response timeout and flags an error on expiry.
- Sits between the core datapath (PC / ALUResult / WriteData / ReadData paths) and the memory model. The core stalls while waiting for valid.

---
 rtl/mem_arbiter.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the instruction-fetch
// port and the load/store data port. One transaction is in flight at a time.
// Simultaneous requests are granted round-robin. Read data returns with a
// registered one-cycle valid pulse. A memory response that takes too long
// aborts the transaction and raises err together with that valid.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_valid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_BUSY_I = 2'd1;
    localparam logic [1:0] ST_BUSY_D = 2'd2;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_D  = 1'b1;

    // A zero TIMEOUT disables the watchdog; keep at least one counter bit.
    localparam int              CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]        state_r;
    logic              rr_last_r;
    logic [CNT_W-1:0]  tmo_cnt_r;
    logic              mem_req_r;
    logic              mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_wdata_r;
    logic              if_valid_r;
    logic              d_valid_r;
    logic              err_r;
    logic [DATA_W-1:0] if_rdata_r;
    logic [DATA_W-1:0] d_rdata_r;

    logic              grant_if_s;
    logic              grant_d_s;
    logic              busy_s;
    logic              done_s;
    logic              abort_s;
    logic              finish_s;

    // Grant decision: only in IDLE (and out of reset), tie goes to the port not served last.
    always_comb begin
        grant_if_s = 1'b0;
        grant_d_s  = 1'b0;
        if ((state_r == ST_IDLE) && reset) begin
            if (if_req && d_req) begin
                if (rr_last_r == PORT_D) begin
                    grant_if_s = 1'b1;
                end else begin
                    grant_d_s = 1'b1;
                end
            end else if (if_req) begin
                grant_if_s = 1'b1;
            end else if (d_req) begin
                grant_d_s = 1'b1;
            end else begin
                grant_if_s = 1'b0;
                grant_d_s  = 1'b0;
            end
        end else begin
            grant_if_s = 1'b0;
            grant_d_s  = 1'b0;
        end
    end

    // Completion qualifiers: ready wins over a watchdog expiry in the same cycle.
    always_comb begin
        busy_s   = (state_r == ST_BUSY_I) || (state_r == ST_BUSY_D);
        done_s   = busy_s && mem_ready;
        if (TIMEOUT > 0) begin
            abort_s = busy_s && !mem_ready && (tmo_cnt_r == CNT_LAST);
        end else begin
            abort_s = 1'b0;
        end
        finish_s = done_s || abort_s;
    end

    // Transaction state machine.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (grant_if_s) begin
                        state_r <= ST_BUSY_I;
                    end else if (grant_d_s) begin
                        state_r <= ST_BUSY_D;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_BUSY_I, ST_BUSY_D: begin
                    if (finish_s) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= state_r;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // Remember the most recently granted port for round-robin tie breaking.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_last_r <= PORT_D;
        end else if (grant_if_s) begin
            rr_last_r <= PORT_IF;
        end else if (grant_d_s) begin
            rr_last_r <= PORT_D;
        end else begin
            rr_last_r <= rr_last_r;
        end
    end

    // Memory-wait watchdog: cleared on grant, counts BUSY cycles without ready.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_cnt_r <= '0;
        end else if (grant_if_s || grant_d_s || finish_s) begin
            tmo_cnt_r <= '0;
        end else if (busy_s) begin
            tmo_cnt_r <= tmo_cnt_r + CNT_ONE;
        end else begin
            tmo_cnt_r <= tmo_cnt_r;
        end
    end

    // Memory request: raised on grant and held stable until the transaction ends.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
        end else if (grant_if_s) begin
            mem_req_r   <= 1'b1;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= if_addr;
            mem_wdata_r <= '0;
        end else if (grant_d_s) begin
            mem_req_r   <= 1'b1;
            mem_we_r    <= d_we;
            mem_addr_r  <= d_addr;
            mem_wdata_r <= d_wdata;
        end else if (finish_s) begin
            mem_req_r   <= 1'b0;
            mem_we_r    <= mem_we_r;
            mem_addr_r  <= mem_addr_r;
            mem_wdata_r <= mem_wdata_r;
        end else begin
            mem_req_r   <= mem_req_r;
            mem_we_r    <= mem_we_r;
            mem_addr_r  <= mem_addr_r;
            mem_wdata_r <= mem_wdata_r;
        end
    end

    // One-cycle response pulses for the port whose transaction just ended.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            if_valid_r <= 1'b0;
            d_valid_r  <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            if_valid_r <= finish_s && (state_r == ST_BUSY_I);
            d_valid_r  <= finish_s && (state_r == ST_BUSY_D);
            err_r      <= abort_s;
        end
    end

    // Fetch data register: load on success, zero on abort, otherwise hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            if_rdata_r <= '0;
        end else if ((state_r == ST_BUSY_I) && done_s) begin
            if_rdata_r <= mem_rdata;
        end else if ((state_r == ST_BUSY_I) && abort_s) begin
            if_rdata_r <= '0;
        end else begin
            if_rdata_r <= if_rdata_r;
        end
    end

    // Load data register: successful stores leave it untouched.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d_rdata_r <= '0;
        end else if ((state_r == ST_BUSY_D) && done_s && !mem_we_r) begin
            d_rdata_r <= mem_rdata;
        end else if ((state_r == ST_BUSY_D) && abort_s) begin
            d_rdata_r <= '0;
        end else begin
            d_rdata_r <= d_rdata_r;
        end
    end

    assign if_gnt    = grant_if_s;
    assign d_gnt     = grant_d_s;
    assign if_valid  = if_valid_r;
    assign d_valid   = d_valid_r;
    assign err       = err_r;
    assign if_rdata  = if_rdata_r;
    assign d_rdata   = d_rdata_r;
    assign mem_req   = mem_req_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;

endmodule
